// File: rtl/uart_rx_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_stream_ctrl                                             |
// | Purpose  : Polls the UART RX ring-buffer peripheral (tail / wrap count),   |
// |            fetches 32-bit buffer words and streams them out as an in-order |
// |            byte stream with valid/ready. Detects producer overrun.         |
// | Options  : UART_RX_CTRL_STATS_EN - adds delivered-byte / overrun counters  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_rx_stream_ctrl #(
   parameter logic [31:0] TAIL_ADDR     = 32'h0000_0400,
   parameter logic [31:0] COUNT_ADDR    = 32'h0000_0404,
   parameter int          POLL_INTERVAL = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        mem_cmd_start,
   output logic        mem_cmd_write,
   input  logic        mem_cmd_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rdata_valid,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overflow,
   output logic [15:0] stat_overflows,
   output logic [31:0] stat_bytes
);

   localparam logic [15:0] c_poll_last  = 16'(POLL_INTERVAL - 1);
   localparam logic [41:0] c_ring_bytes = 42'd1024;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_CNT0 = 3'd1,
      S_RD_TAIL = 3'd2,
      S_RD_CNT1 = 3'd3,
      S_EVAL    = 3'd4,
      S_FETCH   = 3'd5,
      S_EMIT    = 3'd6,
      S_WAIT    = 3'd7
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_cmd_start;   // command requested, not yet accepted
   logic        r_pending;     // command accepted, response not yet captured
   logic [1:0]  r_age;         // cycles since issue, saturating at 2
   logic [31:0] r_addr;
   logic [31:0] r_c0;
   logic [9:0]  r_tail;
   logic [31:0] r_rd_wraps;
   logic [9:0]  r_rd_ptr;
   logic [41:0] r_avail;
   logic [31:0] r_word;
   logic [15:0] r_poll;
   logic        r_overflow;

   logic        w_issue;
   logic        w_capture;
   logic        w_hs;
   logic        w_want_cmd;
   logic        w_no_cmd;
   logic [31:0] w_cmd_addr;
   logic [41:0] w_cons;
   logic [41:0] w_prod_new;

   assign w_cons     = {r_rd_wraps, r_rd_ptr};
   assign w_prod_new = {mem_rdata, r_tail};
   assign w_issue    = r_cmd_start && mem_cmd_ready;
   // Response is only trusted from the second cycle after issue onwards
   assign w_capture  = r_pending && (r_age == 2'd2) && mem_cmd_ready && mem_rdata_valid;
   assign w_no_cmd   = !r_cmd_start && !r_pending;
   assign out_valid  = (r_state == S_EMIT);
   assign w_hs       = out_valid && out_ready;

   assign mem_cmd_start = r_cmd_start;
   assign mem_cmd_write = 1'b0;
   assign mem_addr      = r_addr;
   assign mem_wdata     = 32'h0;
   assign out_data      = r_word[{r_rd_ptr[1:0], 3'b000} +: 8];
   assign overflow      = r_overflow;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic and command request selection
   always_comb begin
      w_next     = r_state;
      w_want_cmd = 1'b0;
      w_cmd_addr = COUNT_ADDR;
      case (r_state)
         S_IDLE: begin
            if (enable) w_next = S_RD_CNT0;
         end
         S_RD_CNT0: begin
            w_want_cmd = 1'b1;
            if (w_capture)                 w_next = enable ? S_RD_TAIL : S_IDLE;
            else if (!enable && w_no_cmd)  w_next = S_IDLE;
         end
         S_RD_TAIL: begin
            w_want_cmd = 1'b1;
            w_cmd_addr = TAIL_ADDR;
            if (w_capture)                 w_next = enable ? S_RD_CNT1 : S_IDLE;
            else if (!enable && w_no_cmd)  w_next = S_IDLE;
         end
         S_RD_CNT1: begin
            w_want_cmd = 1'b1;
            if (w_capture) begin
               if (!enable)                w_next = S_IDLE;
               else if (mem_rdata != r_c0) w_next = S_RD_CNT0;  // torn read
               else                        w_next = S_EVAL;
            end else if (!enable && w_no_cmd) begin
               w_next = S_IDLE;
            end
         end
         S_EVAL: begin
            if (r_avail > c_ring_bytes)    w_next = S_WAIT;
            else if (r_avail == 42'd0)     w_next = S_WAIT;
            else                           w_next = S_FETCH;
         end
         S_FETCH: begin
            w_want_cmd = 1'b1;
            w_cmd_addr = {22'b0, r_rd_ptr[9:2], 2'b00};
            if (w_capture)                 w_next = enable ? S_EMIT : S_IDLE;
            else if (!enable && w_no_cmd)  w_next = S_IDLE;
         end
         S_EMIT: begin
            if (w_hs) begin
               if (!enable)                   w_next = S_IDLE;
               else if (r_avail == 42'd1)     w_next = S_RD_CNT0;
               else if (r_rd_ptr[1:0] == 2'd3) w_next = S_FETCH;
            end
         end
         S_WAIT: begin
            if (!enable || r_poll == c_poll_last) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      w_want_cmd = w_want_cmd && enable && w_no_cmd;
   end

   // Command handshake, position tracking and data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmd_start <= 1'b0;
         r_pending   <= 1'b0;
         r_age       <= 2'd0;
         r_addr      <= 32'h0;
         r_c0        <= 32'h0;
         r_tail      <= 10'h0;
         r_rd_wraps  <= 32'h0;
         r_rd_ptr    <= 10'h0;
         r_avail     <= 42'h0;
         r_word      <= 32'h0;
         r_poll      <= 16'h0;
         r_overflow  <= 1'b0;
      end else begin
         r_overflow <= 1'b0;
         r_poll     <= (r_state == S_WAIT) ? r_poll + 16'd1 : 16'd0;

         if (w_issue) begin
            r_cmd_start <= 1'b0;
            r_pending   <= 1'b1;
            r_age       <= 2'd1;
         end else if (w_capture) begin
            r_pending   <= 1'b0;
         end else if (r_pending) begin
            if (r_age != 2'd2) r_age <= r_age + 2'd1;
         end else if (w_want_cmd) begin
            r_cmd_start <= 1'b1;
            r_addr      <= w_cmd_addr;
         end

         // Captured data is dropped when the controller is being parked
         if (w_capture && enable) begin
            case (r_state)
               S_RD_CNT0: r_c0   <= mem_rdata;
               S_RD_TAIL: r_tail <= mem_rdata[9:0];
               S_RD_CNT1: if (mem_rdata == r_c0) r_avail <= w_prod_new - w_cons;
               S_FETCH:   r_word <= mem_rdata;
               default: ;
            endcase
         end

         // Overrun: jump the consumer straight to the producer position
         if (r_state == S_EVAL && r_avail > c_ring_bytes) begin
            {r_rd_wraps, r_rd_ptr} <= w_cons + r_avail;
            r_overflow             <= 1'b1;
         end

         if (w_hs) begin
            {r_rd_wraps, r_rd_ptr} <= w_cons + 42'd1;
            r_avail                <= r_avail - 42'd1;
         end
      end
   end

`ifdef UART_RX_CTRL_STATS_EN
   logic [15:0] r_stat_ovf;
   logic [31:0] r_stat_bytes;

   // Delivered-byte (wrapping) and overrun (saturating) counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_ovf   <= 16'h0;
         r_stat_bytes <= 32'h0;
      end else begin
         if (w_hs)                                r_stat_bytes <= r_stat_bytes + 32'd1;
         if (r_overflow && r_stat_ovf != 16'hFFFF) r_stat_ovf  <= r_stat_ovf + 16'd1;
      end
   end

   assign stat_overflows = r_stat_ovf;
   assign stat_bytes     = r_stat_bytes;
`else
   assign stat_overflows = 16'h0;
   assign stat_bytes     = 32'h0;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx_stream_ctrl.md
Name: uart_rx_stream_ctrl

Overview:
- Sequences the memory-mapped UART RX ring-buffer peripheral through its start/ready command handshake.
- Polls the peripheral's tail and wrap-count registers, fetches 32-bit buffer words, and unpacks them into an in-order byte stream with valid/ready.
- Detects producer overrun of the 1024-byte ring.
- Sits between the UART RX MMIO slave and a consumer such as a boot loader or debug monitor, replacing CPU polling loops.

Parameters:
- TAIL_ADDR, 32'h0000_0400: peripheral offset of the tail register (10-bit byte index).
- COUNT_ADDR, 32'h0000_0404: peripheral offset of the wrap-count register (increments when tail wraps 1023->0).
- POLL_INTERVAL, 16: idle cycles between producer-position polls when no data is available; must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = controller runs; 0 = finish the outstanding command, then park in IDLE
- mem_cmd_start  out  1  command request to the peripheral
- mem_cmd_write  out  1  always 0
- mem_cmd_ready  in  1  peripheral accepts a command when high
- mem_addr  out  32  command address; held stable from issue until capture
- mem_wdata  out  32  always 0
- mem_rdata  in  32  peripheral read data
- mem_rdata_valid  in  1  peripheral read data valid
- out_data  out  8  received byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts the byte
- overflow  out  1  one-cycle pulse when an overrun is detected
- stat_overflows  out  16  overrun count; 0 when the optional feature is off
- stat_bytes  out  32  delivered-byte count; 0 when the optional feature is off

Behaviour:
- Reset values: mem_cmd_start=0, mem_addr=0, out_valid=0, out_data=0, overflow=0, all counters=0, rd_ptr=0, rd_wraps=0, state=IDLE.
- Command handshake:
  - A command issues on a cycle with mem_cmd_start && mem_cmd_ready; mem_cmd_start drops the following cycle.
  - Capture mem_rdata on the first cycle at least 2 cycles after issue where mem_cmd_ready && mem_rdata_valid.
  - Exactly one command is outstanding at any time.
- Position arithmetic:
  - Producer position P = {count, tail} (42 bits).
  - Consumer position C = {rd_wraps, rd_ptr}.
  - avail = P - C, computed modulo 2^42.
- States:
  - IDLE: if enable, go to RD_CNT0.
  - RD_CNT0: read COUNT_ADDR into c0.
  - RD_TAIL: read TAIL_ADDR.
  - RD_CNT1: read COUNT_ADDR into c1.
    - If c1 != c0, go to RD_CNT0; this is a torn read, so retry.
    - Otherwise compute P and go to EVAL.
  - EVAL:
    - If avail > 1024: set C = P - 0 (discard everything), pulse overflow, go to WAIT.
    - Else if avail == 0: go to WAIT.
    - Else: go to FETCH.
  - FETCH: read word address {22'b0, rd_ptr[9:2], 2'b00} into a word register, then go to EMIT.
  - EMIT:
    - Present byte rd_ptr[1:0] of the word register on out_data with out_valid=1.
    - On out_valid && out_ready, increment C by 1 (rd_ptr 1023->0 increments rd_wraps) and decrement the local avail.
    - After a handshake: if avail == 0, go to RD_CNT0. Else if rd_ptr[1:0] wrapped to 0, go to FETCH. Otherwise stay in EMIT.
    - out_data stays stable while out_valid && !out_ready.
  - WAIT: count POLL_INTERVAL cycles, then go to IDLE.
- A partially written word is fetched but only bytes below P are emitted. Remaining bytes are delivered after a refetch following the next poll.
- Overrun is detected only at EVAL. Bytes already in the word register at detection time are not emitted.
- enable falling mid-sequence: the outstanding command completes and its data is discarded; out_valid drops only after the current byte handshakes; then go to IDLE. C is retained.
- reset mid-command: returns to IDLE immediately; the peripheral's late response is ignored.

Optional Feature:
- UART_RX_CTRL_STATS_EN defined:
  - stat_bytes increments on each out handshake and wraps at 2^32.
  - stat_overflows increments on each overflow pulse and saturates at 16'hFFFF.
- Macro undefined: both stat ports are tied to 0 and the counter registers are not instantiated.

Test Plan:
- Peripheral model holds tail=5, count=0; consumer always ready -> bytes at indices 0..4 emitted in order with values matching the buffer; controller then polls and idles; stat_bytes=5.
- tail=2, then after 50 cycles tail=6 -> bytes 0,1 emitted; word 0 refetched; bytes 2,3 emitted from the refetch; bytes 4,5 emitted from word 1; no duplicates.
- rd at 1022, producer at count=1, tail=2 -> bytes 1022, 1023, 0, 1 delivered; rd_wraps=1.
- Producer jumps to count=2, tail=10 while C=0 -> overflow pulses once, no byte emitted, C=2058; stat_overflows=1.
- Model returns count 0 then 1 across the tail read -> controller re-issues COUNT_ADDR; P uses the coherent triple.
- out_ready held low for 20 cycles with out_valid=1 -> out_data stable and no new command issued; enable deasserted mid-FETCH -> command completes, state returns to IDLE, mem_cmd_start stays 0 thereafter.
